// File: rtl/dram_write_controller.sv
// Producer-side DRAM ring-buffer write controller with trigger/post-trigger capture.
// Optional wrap counter enabled by defining WRAP_COUNT_EN.
module dram_write_controller #(
    parameter int unsigned        ADDR_W    = 24,
    parameter int unsigned        DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  ADDR_LAST = {ADDR_W{1'b1}},
    parameter logic [ADDR_W-1:0]  POST_TRIG = ADDR_W'(1024)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              trigger,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_wr_data,
    output logic              dram_wr_en,
    input  logic              dram_wr_ack,
    output logic              done,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              wrapped,
    output logic              overflow,
    output logic [1:0]        state,
    output logic [15:0]       wrap_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        POST = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                hv_q, hv_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   trig_q, trig_d;
    logic [ADDR_W-1:0]   post_q, post_d;
    logic                wrapped_q, wrapped_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;

    logic accepting;
    logic ready;
    logic capture;
    logic complete;
    logic at_last;

    // The stream cannot stall, so any cycle we are accepting but not ready loses a word.
    assign accepting = (state_q == RUN) || ((state_q == POST) && (post_q < POST_TRIG));
    assign ready     = accepting && en && (!hv_q || dram_wr_ack);
    assign capture   = din_valid && ready;
    assign complete  = hv_q && dram_wr_ack;
    assign at_last   = (addr_q == ADDR_LAST);

    always_comb begin
        state_d   = state_q;
        hv_d      = hv_q;
        data_d    = data_q;
        addr_d    = addr_q;
        wr_ptr_d  = wr_ptr_q;
        trig_d    = trig_q;
        post_d    = post_q;
        wrapped_d = wrapped_q;
        ovf_d     = ovf_q;
        done_d    = done_q;

        if (complete) begin
            wr_ptr_d = addr_q;
            addr_d   = at_last ? '0 : addr_q + 1'b1;
            hv_d     = 1'b0;
            if (at_last) begin
                wrapped_d = 1'b1;
            end
        end
        if (capture) begin
            hv_d   = 1'b1;
            data_d = din;
        end
        if (din_valid && !ready && accepting) begin
            ovf_d = 1'b1;
        end

        // A word held at trigger time is pre-trigger; one captured in the trigger cycle is post.
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d   = RUN;
                    addr_d    = '0;
                    wr_ptr_d  = '0;
                    trig_d    = '0;
                    post_d    = '0;
                    wrapped_d = 1'b0;
                    ovf_d     = 1'b0;
                    done_d    = 1'b0;
                end
            end
            RUN: begin
                if (en && trigger) begin
                    state_d   = POST;
                    trig_d    = addr_q;
                    post_d    = '0;
                    post_d[0] = capture;
                end else if (!en && !hv_q) begin
                    state_d = IDLE;
                end
            end
            POST: begin
                if (capture) begin
                    post_d = post_q + 1'b1;
                end
                if (!en && !hv_q) begin
                    state_d = IDLE;
                end else if ((post_q >= POST_TRIG) && !hv_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                if (!en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            hv_q      <= 1'b0;
            data_q    <= '0;
            addr_q    <= '0;
            wr_ptr_q  <= '0;
            trig_q    <= '0;
            post_q    <= '0;
            wrapped_q <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hv_q      <= hv_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            wr_ptr_q  <= wr_ptr_d;
            trig_q    <= trig_d;
            post_q    <= post_d;
            wrapped_q <= wrapped_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

`ifdef WRAP_COUNT_EN
    logic [15:0] wrap_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_cnt_q <= '0;
        end else if ((state_q == IDLE) && en) begin
            wrap_cnt_q <= '0;
        end else if (complete && at_last && (wrap_cnt_q != 16'hFFFF)) begin
            wrap_cnt_q <= wrap_cnt_q + 16'd1;
        end
    end

    assign wrap_cnt = wrap_cnt_q;
`else
    assign wrap_cnt = '0;
`endif

    assign din_ready    = ready;
    assign dram_addr    = addr_q;
    assign dram_wr_data = data_q;
    assign dram_wr_en   = hv_q;
    assign done         = done_q;
    assign wr_ptr       = wr_ptr_q;
    assign trig_addr    = trig_q;
    assign wrapped      = wrapped_q;
    assign overflow     = ovf_q;
    assign state        = state_q;

endmodule

// File: tb/tb_dram_write_controller.sv
// Self-checking bench for dram_write_controller: directed scenarios plus random traffic
// against a count/modulo based reference model. Honours WRAP_COUNT_EN.
module tb_dram_write_controller;

    localparam int M1  = 8;   // ring size of main instance (ADDR_LAST=7)
    localparam int PT1 = 4;

`ifdef WRAP_COUNT_EN
    localparam logic [15:0] EXP_WRAPS1 = 16'd2;
    localparam logic [15:0] EXP_WRAPS2 = 16'd1;
`else
    localparam logic [15:0] EXP_WRAPS1 = 16'd0;
    localparam logic [15:0] EXP_WRAPS2 = 16'd0;
`endif

    logic        clk, rst, en, trigger, dinValid, dramWrAck;
    logic [31:0] din;

    logic        dinReady, dramWrEn, done, wrapped, overflow;
    logic [23:0] dramAddr, wrPtr, trigAddr;
    logic [31:0] dramWrData;
    logic [1:0]  state;
    logic [15:0] wrapCnt;

    logic        dinReady2, dramWrEn2, done2, wrapped2, overflow2;
    logic [23:0] dramAddr2, wrPtr2, trigAddr2;
    logic [31:0] dramWrData2;
    logic [1:0]  state2;
    logic [15:0] wrapCnt2;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: progress is tracked as counts; addresses derive from them by modulo.
    int          mPh;
    bit          mHold;
    logic [31:0] mHoldData;
    int          mWrites;
    int          mTrig;
    bit          mOvf;
    bit          mDone;
    int          mPost;

    dram_write_controller #(.ADDR_W(24), .DATA_W(32), .ADDR_LAST(24'd7), .POST_TRIG(24'd4)) dut (
        .clk(clk), .rst(rst), .en(en), .trigger(trigger), .din(din), .din_valid(dinValid),
        .din_ready(dinReady), .dram_addr(dramAddr), .dram_wr_data(dramWrData),
        .dram_wr_en(dramWrEn), .dram_wr_ack(dramWrAck), .done(done), .wr_ptr(wrPtr),
        .trig_addr(trigAddr), .wrapped(wrapped), .overflow(overflow), .state(state),
        .wrap_cnt(wrapCnt)
    );

    dram_write_controller #(.ADDR_W(24), .DATA_W(32), .ADDR_LAST(24'd11), .POST_TRIG(24'd0)) dut2 (
        .clk(clk), .rst(rst), .en(en), .trigger(trigger), .din(din), .din_valid(dinValid),
        .din_ready(dinReady2), .dram_addr(dramAddr2), .dram_wr_data(dramWrData2),
        .dram_wr_en(dramWrEn2), .dram_wr_ack(dramWrAck), .done(done2), .wr_ptr(wrPtr2),
        .trig_addr(trigAddr2), .wrapped(wrapped2), .overflow(overflow2), .state(state2),
        .wrap_cnt(wrapCnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] expAddr();
        return 24'(mWrites % M1);
    endfunction

    function automatic logic [23:0] expPtr();
        return (mWrites == 0) ? 24'd0 : 24'((mWrites - 1) % M1);
    endfunction

    function automatic logic [15:0] expWrapCnt();
`ifdef WRAP_COUNT_EN
        return ((mWrites / M1) > 65535) ? 16'hFFFF : 16'(mWrites / M1);
`else
        return 16'd0;
`endif
    endfunction

    function automatic bit expReady();
        return ((mPh == 1) || (mPh == 2 && mPost < PT1)) && en && (!mHold || dramWrAck);
    endfunction

    task automatic modelReset();
        mPh = 0; mHold = 0; mHoldData = '0; mWrites = 0;
        mTrig = 0; mOvf = 0; mDone = 0; mPost = 0;
    endtask

    task automatic modelStep();
        int oldPh, oldPost, oldWrites;
        bit oldHold, acc, rdy, cap, cmp;
        oldPh = mPh; oldPost = mPost; oldWrites = mWrites; oldHold = mHold;
        acc = (oldPh == 1) || (oldPh == 2 && oldPost < PT1);
        rdy = expReady();
        cap = dinValid && rdy;
        cmp = oldHold && dramWrAck;
        if (dinValid && !rdy && acc) mOvf = 1;
        if (cmp) begin mWrites++; mHold = 0; end
        if (cap) begin mHold = 1; mHoldData = din; end
        case (oldPh)
            0: if (en) begin
                   mPh = 1; mWrites = 0; mTrig = 0; mOvf = 0; mDone = 0; mPost = 0;
               end
            1: if (en && trigger) begin
                   mPh = 2; mTrig = oldWrites % M1; mPost = cap ? 1 : 0;
               end else if (!en && !oldHold) begin
                   mPh = 0;
               end
            2: begin
                   if (cap) mPost++;
                   if (!en && !oldHold) mPh = 0;
                   else if (oldPost >= PT1 && !oldHold) begin mPh = 3; mDone = 1; end
               end
            default: if (!en) mPh = 0;
        endcase
    endtask

    // Inputs change at the falling edge; outputs are observed 1 time unit later.
    task automatic setIn(input bit e, input bit t, input bit v, input bit a, input logic [31:0] d);
        en = e; trigger = t; dinValid = v; dramWrAck = a; din = d;
        #1;
    endtask

    task automatic tick();
        modelStep();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        setIn(0, 0, 0, 0, 32'd0);
        @(negedge clk);
        assertCount++;
        if ({dinReady, dramAddr, dramWrData, dramWrEn, done, wrPtr, trigAddr, wrapped, overflow, state, wrapCnt} !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: got addr=%0h data=%0h wren=%0b state=%0d, required all zero",
                     dramAddr, dramWrData, dramWrEn, state);
        end
        rst = 1'b0;
        modelReset();
        setIn(1, 0, 0, 0, 32'd0);
        tick();
        setIn(1, 0, 1, 0, 32'hCAFE0001);
        tick();
        setIn(1, 0, 0, 0, 32'd0);
        assertCount++;
        if (dramWrEn !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL midwrite_pending: dram_wr_en got %0b required 1", dramWrEn);
        end
        rst = 1'b1;
        en = 1'b0;
        #1;
        assertCount++;
        if (dramWrEn !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL async_reset_wren: dram_wr_en got %0b required 0", dramWrEn);
        end
        assertCount++;
        if ({dinReady, dramAddr, dramWrData, done, wrPtr, trigAddr, wrapped, overflow, state, wrapCnt} !== '0) begin
            failCount++;
            $display("[TB] FAIL async_reset_outputs: got data=%0h state=%0d, required all zero", dramWrData, state);
        end
        @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    task automatic test_ring_capture();
        bit t, v;
        int n;
        setIn(1, 0, 0, 0, 32'd0);
        tick();
        n = 0;
        while (mPh != 3 && n < 60) begin
            t = (mPh == 1) && !mHold && (mWrites % M1 == 5);
            v = t ? 1'b1 : !((mPh == 1) && mHold && (mWrites % M1 == 4));
            setIn(1, t, v, 1, $urandom);
            assertCount++;
            if (dramAddr !== expAddr() || state !== 2'(mPh)) begin
                failCount++;
                $display("[TB] FAIL ring_progress: addr=%0h state=%0d required addr=%0h state=%0d",
                         dramAddr, state, expAddr(), mPh);
            end
            tick();
            n++;
        end
        setIn(1, 0, 1, 1, 32'h12345678);
        assertCount++;
        if (state !== 2'd3 || done !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL ring_done: state=%0d done=%0b required state=3 done=1", state, done);
        end
        assertCount++;
        if (trigAddr !== 24'd5 || wrPtr !== 24'd0 || wrapped !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL ring_result: trig_addr=%0h wr_ptr=%0h wrapped=%0b required 5/0/1",
                     trigAddr, wrPtr, wrapped);
        end
        assertCount++;
        if (dinReady !== 1'b0 || dramWrEn !== 1'b0 || overflow !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL ring_quiet: ready=%0b wren=%0b overflow=%0b required 0/0/0",
                     dinReady, dramWrEn, overflow);
        end
        tick();
        setIn(1, 1, 1, 1, 32'h0);
        tick();
        setIn(0, 0, 0, 0, 32'h0);
        assertCount++;
        if (state !== 2'd3 || wrPtr !== 24'd0 || trigAddr !== 24'd5) begin
            failCount++;
            $display("[TB] FAIL done_frozen: state=%0d wr_ptr=%0h trig_addr=%0h required 3/0/5",
                     state, wrPtr, trigAddr);
        end
        tick();
        setIn(0, 0, 0, 0, 32'h0);
        assertCount++;
        if (state !== 2'd0 || done !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL done_to_idle: state=%0d done=%0b required 0/1", state, done);
        end
    endtask

    task automatic test_ack_delay();
        int n;
        setIn(1, 0, 0, 0, 32'h0);
        tick();
        setIn(1, 0, 0, 0, 32'h0);
        assertCount++;
        if (state !== 2'd1 || done !== 1'b0 || dramAddr !== 24'd0) begin
            failCount++;
            $display("[TB] FAIL rearm_clear: state=%0d done=%0b addr=%0h required 1/0/0", state, done, dramAddr);
        end
        for (int i = 0; i < 24; i++) begin
            setIn(1, 0, 1, (i % 4) == 3, $urandom);
            assertCount++;
            if (dramAddr !== expAddr() || dramWrEn !== mHold || (mHold && dramWrData !== mHoldData)) begin
                failCount++;
                $display("[TB] FAIL ack_wait_hold: addr=%0h wren=%0b data=%0h required %0h/%0b/%0h",
                         dramAddr, dramWrEn, dramWrData, expAddr(), mHold, mHoldData);
            end
            tick();
        end
        setIn(1, 0, 0, 0, 32'h0);
        assertCount++;
        if (overflow !== 1'b1 || dramAddr !== 24'd6) begin
            failCount++;
            $display("[TB] FAIL ack_delay_result: overflow=%0b addr=%0h required 1/6", overflow, dramAddr);
        end
        n = 0;
        while (mPh != 0 && n < 10) begin
            setIn(0, 0, 0, 1, 32'h0);
            tick();
            n++;
        end
        setIn(0, 0, 0, 0, 32'h0);
        assertCount++;
        if (state !== 2'd0 || done !== 1'b0 || dramWrEn !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL drain_idle: state=%0d done=%0b wren=%0b required 0/0/0", state, done, dramWrEn);
        end
    endtask

    task automatic test_en_drop();
        setIn(1, 0, 0, 0, 32'h0);
        tick();
        setIn(1, 0, 1, 0, 32'hA5A5_0001);
        tick();
        for (int i = 0; i < 2; i++) begin
            setIn(0, 0, 1, 0, 32'hDEAD_BEEF);
            assertCount++;
            if (dinReady !== 1'b0 || dramWrEn !== 1'b1 || state !== 2'd1 || dramWrData !== 32'hA5A5_0001) begin
                failCount++;
                $display("[TB] FAIL en_drop_pending: ready=%0b wren=%0b state=%0d data=%0h required 0/1/1/a5a50001",
                         dinReady, dramWrEn, state, dramWrData);
            end
            tick();
        end
        setIn(0, 0, 0, 1, 32'h0);
        tick();
        setIn(0, 0, 0, 0, 32'h0);
        assertCount++;
        if (dramWrEn !== 1'b0 || wrPtr !== 24'd0 || dramAddr !== 24'd1) begin
            failCount++;
            $display("[TB] FAIL en_drop_complete: wren=%0b wr_ptr=%0h addr=%0h required 0/0/1",
                     dramWrEn, wrPtr, dramAddr);
        end
        tick();
        setIn(0, 0, 0, 0, 32'h0);
        assertCount++;
        if (state !== 2'd0 || done !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL en_drop_idle: state=%0d done=%0b required 0/0", state, done);
        end
        tick();
        setIn(1, 0, 0, 0, 32'h0);
        tick();
        setIn(1, 0, 0, 0, 32'h0);
        assertCount++;
        if (dramAddr !== 24'd0 || overflow !== 1'b0 || state !== 2'd1) begin
            failCount++;
            $display("[TB] FAIL en_reraise: addr=%0h overflow=%0b state=%0d required 0/0/1",
                     dramAddr, overflow, state);
        end
    endtask

    task automatic test_post_trig_zero();
        int n;
        rst = 1'b1;
        setIn(0, 0, 0, 0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        setIn(1, 0, 0, 0, 32'h0);
        tick();
        n = 0;
        while (!(mHold && mWrites == 10) && n < 30) begin
            setIn(1, 0, 1, 1, $urandom);
            tick();
            n++;
        end
        setIn(1, 1, 0, 0, 32'h0);
        assertCount++;
        if (dramAddr2 !== 24'd10 || dramWrEn2 !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL pt0_setup: addr=%0h wren=%0b required 10/1", dramAddr2, dramWrEn2);
        end
        tick();
        setIn(1, 0, 0, 1, 32'h0);
        tick();
        n = 0;
        setIn(1, 0, 0, 0, 32'h0);
        while (state2 !== 2'd3 && n < 5) begin
            tick();
            setIn(1, 0, 0, 0, 32'h0);
            n++;
        end
        assertCount++;
        if (state2 !== 2'd3 || done2 !== 1'b1 || wrPtr2 !== 24'd10 || trigAddr2 !== 24'd10) begin
            failCount++;
            $display("[TB] FAIL pt0_done: state=%0d done=%0b wr_ptr=%0h trig_addr=%0h required 3/1/a/a",
                     state2, done2, wrPtr2, trigAddr2);
        end
        n = 0;
        while (mPh != 0 && n < 10) begin
            setIn(0, 0, 0, 1, 32'h0);
            tick();
            n++;
        end
        setIn(0, 0, 0, 0, 32'h0);
        tick();
    endtask

    task automatic test_wrap_count();
        int n;
        setIn(1, 0, 0, 0, 32'h0);
        tick();
        n = 0;
        while (mWrites < 20 && n < 50) begin
            setIn(1, 0, (mWrites + int'(mHold)) < 20, 1, $urandom);
            tick();
            n++;
        end
        setIn(1, 0, 0, 0, 32'h0);
        assertCount++;
        if (wrapCnt !== EXP_WRAPS1 || wrapped !== 1'b1 || dramAddr !== 24'd4 || wrPtr !== 24'd3) begin
            failCount++;
            $display("[TB] FAIL wrap_count_main: wrap_cnt=%0d wrapped=%0b addr=%0h wr_ptr=%0h required %0d/1/4/3",
                     wrapCnt, wrapped, dramAddr, wrPtr, EXP_WRAPS1);
        end
        assertCount++;
        if (wrapCnt2 !== EXP_WRAPS2 || wrapped2 !== 1'b1 || dramAddr2 !== 24'd8) begin
            failCount++;
            $display("[TB] FAIL wrap_count_alt: wrap_cnt=%0d wrapped=%0b addr=%0h required %0d/1/8",
                     wrapCnt2, wrapped2, dramAddr2, EXP_WRAPS2);
        end
        setIn(0, 0, 0, 0, 32'h0);
        tick();
    endtask

    task automatic test_random();
        bit enLevel;
        rst = 1'b1;
        setIn(0, 0, 0, 0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        enLevel = 0;
        for (int i = 0; i < 3000; i++) begin
            if (mPh == 0 && ($urandom % 4) == 0) enLevel = 1;
            else if (mPh == 3 && ($urandom % 6) == 0) enLevel = 0;
            else if ((mPh == 1 || mPh == 2) && ($urandom % 80) == 0) enLevel = 0;
            setIn(enLevel, enLevel && (($urandom % 30) == 0), ($urandom % 100) < 85,
                  ($urandom % 100) < 60, $urandom);
            assertCount++;
            if (state !== 2'(mPh) || dinReady !== expReady() || dramWrEn !== mHold) begin
                failCount++;
                $display("[TB] FAIL rand_ctrl cyc %0d: state=%0d ready=%0b wren=%0b required %0d/%0b/%0b",
                         i, state, dinReady, dramWrEn, mPh, expReady(), mHold);
            end
            assertCount++;
            if (dramAddr !== expAddr() || (mHold && dramWrData !== mHoldData)) begin
                failCount++;
                $display("[TB] FAIL rand_write cyc %0d: addr=%0h data=%0h required %0h/%0h",
                         i, dramAddr, dramWrData, expAddr(), mHoldData);
            end
            assertCount++;
            if (wrPtr !== expPtr() || trigAddr !== 24'(mTrig) || wrapped !== (mWrites >= M1)) begin
                failCount++;
                $display("[TB] FAIL rand_ptrs cyc %0d: wr_ptr=%0h trig=%0h wrapped=%0b required %0h/%0h/%0b",
                         i, wrPtr, trigAddr, wrapped, expPtr(), mTrig, mWrites >= M1);
            end
            assertCount++;
            if (overflow !== mOvf || done !== mDone || wrapCnt !== expWrapCnt()) begin
                failCount++;
                $display("[TB] FAIL rand_flags cyc %0d: overflow=%0b done=%0b wrap_cnt=%0d required %0b/%0b/%0d",
                         i, overflow, done, wrapCnt, mOvf, mDone, expWrapCnt());
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0; trigger = 1'b0; dinValid = 1'b0; dramWrAck = 1'b0; din = '0;
        modelReset();
        test_reset();
        test_ring_capture();
        test_ack_delay();
        test_en_drop();
        test_post_trig_zero();
        test_wrap_count();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/dram_write_controller.md
Name: dram_write_controller

Overview:
- Producer-side controller for the DRAM ring buffer: accepts a streaming word interface and writes words to consecutive DRAM addresses, wrapping at ADDR_LAST.
- On a trigger it writes POST_TRIG further words, then freezes and publishes the last written address (wr_ptr) for the DRAM reader to use as its stop address.
- Sits between the ADC/packetiser stream and the DRAM write port.

Parameters:
- ADDR_W, 24, DRAM word-address width.
- DATA_W, 32, DRAM write data width.
- ADDR_LAST, 24'hFFFFFF, last ring address; the address after ADDR_LAST is 0.
- POST_TRIG, 1024, number of words accepted on or after the trigger cycle before stopping (ADDR_W bits wide).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  arm/run level; 0 stops the capture.
- trigger  in  1  single-cycle capture trigger.
- din  in  DATA_W  stream data.
- din_valid  in  1  stream valid.
- din_ready  out  1  controller can take din this cycle.
- dram_addr  out  ADDR_W  write address.
- dram_wr_data  out  DATA_W  write data.
- dram_wr_en  out  1  write request; held until acknowledged.
- dram_wr_ack  in  1  DRAM accepted the current write.
- done  out  1  capture complete.
- wr_ptr  out  ADDR_W  address of the last word written.
- trig_addr  out  ADDR_W  dram_addr value at the trigger cycle.
- wrapped  out  1  ring has wrapped at least once (sticky).
- overflow  out  1  a word was dropped (sticky).
- state  out  2  FSM state.
- wrap_cnt  out  16  wrap counter (see Optional Feature).

Behaviour:
- Reset: every output is 0. The FSM goes to IDLE. The hold register is emptied. dram_wr_en drops immediately, including in the middle of a write.
- FSM encoding: IDLE=0, RUN=1, POST=2, DONE=3.
- IDLE:
  - din_ready=0.
  - On en=1, go to RUN. In the same transition clear dram_addr, wr_ptr, trig_addr, wrapped, overflow, wrap_cnt, done and the post counter.
- Hold register: a single entry, hv = hold-valid.
  - din_ready = (state is RUN, or POST with post_cnt<POST_TRIG) and en and (!hv or dram_wr_ack).
  - A word is captured on din_valid&din_ready. It appears on dram_wr_data with dram_wr_en=1 from the next cycle.
  - dram_wr_en = hv. dram_addr and dram_wr_data stay stable while dram_wr_en=1 and ack=0.
  - Write completion is dram_wr_en&dram_wr_ack. On completion:
    - wr_ptr <= dram_addr.
    - dram_addr <= (dram_addr==ADDR_LAST) ? 0 : dram_addr+1.
    - On wrap, set wrapped=1.
    - hv clears, unless a new word is captured in the same cycle.
  - Back-to-back ack plus capture sustains 1 word/cycle.
- RUN:
  - trigger=1 moves to POST and latches trig_addr <= dram_addr.
  - A word captured in the trigger cycle counts as post-trigger. A word already in the hold register is pre-trigger and still completes.
- POST:
  - post_cnt increments on each capture.
  - Go to DONE when post_cnt==POST_TRIG and hv=0 (the final ack has completed).
  - POST_TRIG=0: no further captures; DONE as soon as hv=0.
- DONE:
  - done=1, din_ready=0, dram_wr_en=0.
  - wr_ptr, trig_addr and wrapped are frozen.
  - en=0 returns to IDLE. done stays 1 until the next IDLE→RUN transition.
- en=0 in RUN or POST: captures stop. Once hv=0, go to IDLE with done=0. A pending write always completes unless rst is asserted.
- trigger is ignored in IDLE, POST and DONE, and in the cycle en rises.
- overflow is set when din_valid=1 and din_ready=0 while in RUN, or while in POST with post_cnt<POST_TRIG. Back-pressure is therefore treated as loss; the stream has no stall capability.
- Address arithmetic is modulo ADDR_LAST+1; ADDR_LAST need not be a power of two.

Optional Feature:
- Macro: WRAP_COUNT_EN.
- Defined: wrap_cnt increments on every wrap, saturating at 16'hFFFF, and is cleared on IDLE→RUN.
- Undefined: wrap_cnt is tied to 0 and no counter logic is built. wrapped behaves identically in both cases.

Test Plan:
- Reset mid-write (dram_wr_en=1, ack=0), rst pulse → dram_wr_en=0 asynchronously; all outputs 0; state=0.
- ADDR_LAST=7, POST_TRIG=4, continuous valid, ack always 1, trigger when dram_addr=5 → trig_addr=5; words written at 5,6,7,0; wr_ptr=0; wrapped=1; done=1; state=3.
- Ack delayed 3 cycles per write with continuous valid → dram_addr/data stable during the wait; overflow=1; after ack, addr advances by exactly 1.
- POST_TRIG=0, trigger while hv=1 at addr 10 → the held word is written at 10; DONE with wr_ptr=10, trig_addr=10.
- en dropped in RUN with a pending write → the write completes; state returns to 0; done=0; re-raising en clears addr to 0.
- With WRAP_COUNT_EN defined, ADDR_LAST=3, 13 writes → wrap_cnt=3. Without the macro, the same stimulus gives wrap_cnt=0 and wrapped=1.
